// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared pipeline constants and the fetch-control FSM encoding.
package pipe_pkg;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_stage_ctrl_pc_reg.sv
// Program counter with hold enable and a redirect-target load that beats the hold.
module pc_reg #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              load,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4
);

  // Sequential increment wraps naturally at 2^DATA_W.
  assign pc_plus4 = pc + DATA_W'(4);

  always_ff @(posedge clk) begin
    if (reset)      pc <= RESET_PC;
    else if (load)  pc <= target;
    else if (!hold) pc <= pc_plus4;
  end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// Fetch-side control: owns PC and IF/ID, applies hazard stalls, squashes on MEM-stage redirects.
module if_id_stage_ctrl #(
  parameter int                DATA_W    = pipe_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(pipe_pkg::RESET_PC),
  parameter int                MAX_STALL = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hazard,
  input  logic              MBranchTaken,
  input  logic [DATA_W-1:0] MTarget,
  input  logic [DATA_W-1:0] IFInstr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IDInstr,
  output logic [DATA_W-1:0] IDPCPlus4,
  output logic              IDValid,
  output logic              IDEXBubble,
  output logic              FlushEX,
  output logic [1:0]        StallCount,
  output logic              StallErr
);

  import pipe_pkg::*;

  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

  fetch_state_t      state, state_next;
  logic              stall;
  logic [DATA_W-1:0] pc_plus4;

  // A redirect always wins, and a hazard against an empty slot has nothing to protect.
  assign stall      = Hazard & IDValid & ~MBranchTaken;
  assign IDEXBubble = stall | MBranchTaken | ~IDValid;
  assign FlushEX    = MBranchTaken;

  pc_reg #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (Clk),
    .reset    (Reset),
    .hold     (stall),
    .load     (MBranchTaken),
    .target   (MTarget),
    .pc       (PC),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      IDInstr   <= NOP;
      IDPCPlus4 <= '0;
      IDValid   <= 1'b0;
    end else if (MBranchTaken) begin
      IDInstr   <= NOP;
      IDPCPlus4 <= '0;
      IDValid   <= 1'b0;
    end else if (!stall) begin
      IDInstr   <= IFInstr;
      IDPCPlus4 <= pc_plus4;
      IDValid   <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (MBranchTaken) begin
      state_next = FLUSH;
    end else begin
      case (state)
        RUN:     state_next = stall ? STALL : RUN;
        STALL:   state_next = stall ? STALL : RUN;
        FLUSH:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // StallErr latches on the stall cycle that would push past the legal length.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= 2'd0;
      StallErr   <= 1'b0;
    end else begin
      if (stall) begin
        if (StallCount != 2'd3) StallCount <= StallCount + 2'd1;
        if (int'(StallCount) == MAX_STALL) StallErr <= 1'b1;
      end else begin
        StallCount <= 2'd0;
      end
    end
  end

endmodule

// File: doc/if_id_stage_ctrl.md
# if_id_stage_ctrl

Fetch-side consumer of the hazard unit's stall request and of the MEM-stage branch/jump resolution in the 5-stage pipeline. It owns the PC register and the IF/ID pipeline register. It holds both on a load-use/RAW stall and redirects the PC on a taken branch or jump. On a redirect it squashes the three wrong-path instructions sitting in IF, ID and EX. It also tracks stall length and flags a stall that never clears.

## Interface
Parameters:
- DATA_W, 32, width of PC and instruction
- RESET_PC, 32'h0000_0000, PC value after reset
- MAX_STALL, 3, maximum legal consecutive stall cycles before StallErr sets

Ports:
- Clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Hazard  in  1  stall request from hazard detection (equivalent to IFIDWrite=0/PCWrite=0)
- MBranchTaken  in  1  branch/jump resolved taken in MEM stage, valid this cycle
- MTarget  in  DATA_W  redirect target, qualified by MBranchTaken
- IFInstr  in  DATA_W  instruction memory read data for current PC
- PC  out  DATA_W  current fetch address (registered)
- IDInstr  out  DATA_W  IF/ID instruction (registered)
- IDPCPlus4  out  DATA_W  IF/ID PC+4 (registered)
- IDValid  out  1  IF/ID holds a real instruction (registered)
- IDEXBubble  out  1  force zero control into ID/EX this cycle (combinational)
- FlushEX  out  1  force zero control into EX/MEM this cycle (combinational)
- StallCount  out  2  consecutive stall cycles taken, saturating (registered)
- StallErr  out  1  sticky, stall exceeded MAX_STALL (registered)

## Operation
- Effective stall: Stall = Hazard & IDValid & ~MBranchTaken. Hazard against an invalid IF/ID slot is ignored. A redirect always beats a stall.
- FSM states: RUN, STALL, FLUSH.
  - RUN → STALL when Stall.
  - Any state → FLUSH when MBranchTaken.
  - STALL → RUN when ~Stall and ~MBranchTaken.
  - FLUSH → RUN next cycle unless MBranchTaken again.
- RUN/FLUSH, no redirect: PC <= PC+4; IDInstr <= IFInstr; IDPCPlus4 <= PC+4; IDValid <= 1.
- Stall: PC, IDInstr, IDPCPlus4 and IDValid hold.
- Redirect: PC <= MTarget; IDInstr <= 0 (nop); IDPCPlus4 <= 0; IDValid <= 0.
- IDEXBubble = Stall | MBranchTaken | ~IDValid.
- FlushEX = MBranchTaken.
- PC+4 is modulo 2^DATA_W; 32'hFFFF_FFFC wraps to 0 without error.
- StallCount increments on each Stall cycle and saturates at 3. It clears on any non-stall cycle.
- StallErr sets when Stall is asserted while StallCount == MAX_STALL. It clears only on Reset.

## Timing
- Reset values: PC=RESET_PC, IDInstr=0, IDPCPlus4=0, IDValid=0, state RUN, StallCount=0, StallErr=0. IDEXBubble reads 1 during and after reset until the first valid fetch; FlushEX follows MBranchTaken.
- Fetch latency: instruction at PC appears on IDInstr one cycle later.
- Redirect: MBranchTaken in cycle N sets PC=MTarget at N+1. The target instruction is in IF/ID with IDValid=1 at N+2. IF/ID, ID/EX and EX/MEM carry bubbles for the cycle after N.
- Stall is zero-latency: the hold applies to the edge ending the cycle in which Hazard is high.
- Back-to-back MBranchTaken: each one re-redirects; the last target wins.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.

## Structure
- Shared package pipe_pkg: DATA_W, RESET_PC, NOP_INSTR (32'h0), and the FSM state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2).
- One sub-module, pc_reg: PC register with enable and load-target mux.
- IF/ID register, FSM, stall counter and output logic stay in the top.

## Test plan
- Reset then free-run: IFInstr=32'h2008_0005, Hazard=0 → PC=0,4,8 on successive cycles; IDInstr=32'h2008_0005 and IDValid=1 at cycle 2.
- Single stall with PC=8: Hazard=1 for one cycle → PC stays 8 and IDInstr holds; IDEXBubble=1; StallCount=1, then 0; no StallErr.
- Taken branch: MBranchTaken=1, MTarget=32'h40 → FlushEX=1 and IDEXBubble=1 that cycle; next cycle PC=32'h40 and IDValid=0; following cycle IDValid=1.
- Simultaneous Hazard=1 and MBranchTaken=1 → redirect taken, PC=MTarget, StallCount=0.
- Hazard held 4 cycles with IDValid=1 → StallCount 1,2,3,3; StallErr=1 on the 4th cycle; StallErr stays 1 after Hazard drops.
- PC at 32'hFFFF_FFFC with no stall → PC=0 next cycle; Reset during a stall → all outputs at their reset values on the next edge.
